// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// serial_adder_pkg : constants and types shared across the serial adder path
// Rev 1.0
// ============================================================================
package serial_adder_pkg;

   // Operand width shared by the shifter, the serial adder and the collector.
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } p2s_state_t;

endpackage
`default_nettype wire

// File: rtl/parallel_serial_shifter.sv
`default_nettype none
// ============================================================================
// parallel_serial_shifter : captures two operands, streams them LSB first with
// first/last framing. Optional: P2S_PROTO_ERR_EN adds sticky proto_err output.
// Rev 1.0
// ============================================================================
module parallel_serial_shifter
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bit_ready,
   output logic             bit_valid,
   output logic             a_bit,
   output logic             b_bit,
   output logic             first_bit,
   output logic             last_bit,
   output logic             busy,
   output logic             done
`ifdef P2S_PROTO_ERR_EN
   ,
   output logic             proto_err
`endif
);

   localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   p2s_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      cnt_d      = cnt_q;
      load_ready = 1'b0;
      bit_valid  = 1'b0;
      a_bit      = 1'b0;
      b_bit      = 1'b0;
      first_bit  = 1'b0;
      last_bit   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         IDLE: begin
            // Gated by reset_n so no handshake completes while reset is held.
            load_ready = reset_n;
            if (load_valid) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bit_valid = 1'b1;
            busy      = 1'b1;
            a_bit     = a_sh_q[0];
            b_bit     = b_sh_q[0];
            first_bit = (cnt_q == '0);
            last_bit  = (cnt_q == LAST_IDX);
            if (bit_ready) begin
               a_sh_d = a_sh_q >> 1;
               b_sh_d = b_sh_q >> 1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef P2S_PROTO_ERR_EN
   logic proto_err_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         proto_err_q <= 1'b0;
      end else if (load_valid && (state_q != IDLE)) begin
         proto_err_q <= 1'b1;
      end
   end

   assign proto_err = proto_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parallel_serial_shifter.sv
`default_nettype none
// tb_parallel_serial_shifter : randomized self-checking bench at WIDTH=8 with a
// bit-index reference model and a behavioural serial adder/collector.
module tb_parallel_serial_shifter;

   localparam int W = 8;
   // Observed vector order: {bit_valid,a_bit,b_bit,first_bit,last_bit,busy,done,load_ready}
   localparam logic [7:0] IDLE_V = 8'b0000_0001;
   localparam logic [7:0] DONE_V = 8'b0000_0110;
   localparam logic [7:0] RST_V  = 8'b0000_0000;

   logic         clk = 1'b0;
   logic         reset_n, load_valid, bit_ready;
   logic [W-1:0] a_in, b_in;
   logic         load_ready, bit_valid, a_bit, b_bit, first_bit, last_bit, busy, done;
`ifdef P2S_PROTO_ERR_EN
   logic         proto_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   parallel_serial_shifter #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .bit_ready  (bit_ready),
      .bit_valid  (bit_valid),
      .a_bit      (a_bit),
      .b_bit      (b_bit),
      .first_bit  (first_bit),
      .last_bit   (last_bit),
      .busy       (busy),
      .done       (done)
`ifdef P2S_PROTO_ERR_EN
      ,
      .proto_err  (proto_err)
`endif
   );

   function automatic logic bit_of(input logic [W-1:0] v, input int i);
      logic [W-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   // Expected outputs while beat i of operands (a, b) is presented.
   function automatic logic [7:0] beat_vec(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
      return {1'b1, bit_of(a, i), bit_of(b, i), (i == 0), (i == W - 1), 1'b1, 1'b0, 1'b0};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {bit_valid, a_bit, b_bit, first_bit, last_bit, busy, done, load_ready};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; load_valid = 1'b0; bit_ready = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs_vec() !== RST_V) begin
         errors++; $display("FAIL reset_hold: got %b want %b", obs_vec(), RST_V);
      end
`ifdef P2S_PROTO_ERR_EN
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err);
      end
`endif
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec() !== IDLE_V) begin
         errors++; $display("FAIL reset_release: got %b want %b", obs_vec(), IDLE_V);
      end
   endtask

   task automatic test_basic();
      a_in = 8'hA5; b_in = 8'h3C; load_valid = 1'b1; bit_ready = 1'b1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         checks++;
         if (obs_vec() !== beat_vec(8'hA5, 8'h3C, i)) begin
            errors++; $display("FAIL basic_beat%0d: got %b want %b", i, obs_vec(), beat_vec(8'hA5, 8'h3C, i));
         end
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== DONE_V) begin
         errors++; $display("FAIL basic_done: got %b want %b", obs_vec(), DONE_V);
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== IDLE_V) begin
         errors++; $display("FAIL basic_idle: got %b want %b", obs_vec(), IDLE_V);
      end
   endtask

   task automatic test_stall();
      int k, cyc, stall;
      k = 0; cyc = 0; stall = 0;
      a_in = 8'hA5; b_in = 8'h3C; load_valid = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      while (k < W && cyc < 100) begin
         checks++;
         if (obs_vec() !== beat_vec(8'hA5, 8'h3C, k)) begin
            errors++; $display("FAIL stall_beat%0d_cyc%0d: got %b want %b", k, cyc, obs_vec(), beat_vec(8'hA5, 8'h3C, k));
         end
         if (k == 2 && stall < 3) begin
            bit_ready = 1'b0; stall++;
         end else begin
            bit_ready = 1'b1; k++;
         end
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (cyc !== W + 3) begin
         errors++; $display("FAIL stall_latency: got %0d beats-cycles want %0d", cyc, W + 3);
      end
      checks++;
      if (obs_vec() !== DONE_V) begin
         errors++; $display("FAIL stall_done: got %b want %b", obs_vec(), DONE_V);
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== IDLE_V) begin
         errors++; $display("FAIL stall_idle: got %b want %b", obs_vec(), IDLE_V);
      end
   endtask

   task automatic test_mid_load();
      a_in = 8'hA5; b_in = 8'h3C; load_valid = 1'b1; bit_ready = 1'b1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         checks++;
         if (obs_vec() !== beat_vec(8'hA5, 8'h3C, i)) begin
            errors++; $display("FAIL midload_beat%0d: got %b want %b", i, obs_vec(), beat_vec(8'hA5, 8'h3C, i));
         end
         if (i == 3) begin
            load_valid = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
         end
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== DONE_V) begin
         errors++; $display("FAIL midload_done: got %b want %b", obs_vec(), DONE_V);
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== IDLE_V) begin
         errors++; $display("FAIL midload_idle: got %b want %b", obs_vec(), IDLE_V);
      end
`ifdef P2S_PROTO_ERR_EN
      checks++;
      if (proto_err !== 1'b1) begin
         errors++; $display("FAIL midload_proto_err: got %b want 1", proto_err);
      end
`endif
   endtask

   task automatic test_reset_mid();
      a_in = 8'hA5; b_in = 8'h3C; load_valid = 1'b1; bit_ready = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         checks++;
         if (obs_vec() !== beat_vec(8'hA5, 8'h3C, i)) begin
            errors++; $display("FAIL rstmid_beat%0d: got %b want %b", i, obs_vec(), beat_vec(8'hA5, 8'h3C, i));
         end
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_vec() !== RST_V) begin
         errors++; $display("FAIL rstmid_abandon: got %b want %b", obs_vec(), RST_V);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_vec() !== IDLE_V) begin
         errors++; $display("FAIL rstmid_idle: got %b want %b", obs_vec(), IDLE_V);
      end
`ifdef P2S_PROTO_ERR_EN
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_proto_err: got %b want 0", proto_err);
      end
`endif
      a_in = 8'h01; b_in = 8'h01; load_valid = 1'b1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         checks++;
         if (obs_vec() !== beat_vec(8'h01, 8'h01, i)) begin
            errors++; $display("FAIL rstmid_new_beat%0d: got %b want %b", i, obs_vec(), beat_vec(8'h01, 8'h01, i));
         end
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== DONE_V) begin
         errors++; $display("FAIL rstmid_new_done: got %b want %b", obs_vec(), DONE_V);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      a_in = 8'h0F; b_in = 8'hF0; load_valid = 1'b1; bit_ready = 1'b1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (i == 0) begin
            a_in = 8'h81; b_in = 8'h18;
         end
         checks++;
         if (obs_vec() !== beat_vec(8'h0F, 8'hF0, i)) begin
            errors++; $display("FAIL b2b_first_beat%0d: got %b want %b", i, obs_vec(), beat_vec(8'h0F, 8'hF0, i));
         end
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== DONE_V) begin
         errors++; $display("FAIL b2b_first_done: got %b want %b", obs_vec(), DONE_V);
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== IDLE_V) begin
         errors++; $display("FAIL b2b_gap_idle: got %b want %b", obs_vec(), IDLE_V);
      end
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         checks++;
         if (obs_vec() !== beat_vec(8'h81, 8'h18, i)) begin
            errors++; $display("FAIL b2b_second_beat%0d: got %b want %b", i, obs_vec(), beat_vec(8'h81, 8'h18, i));
         end
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== DONE_V) begin
         errors++; $display("FAIL b2b_second_done: got %b want %b", obs_vec(), DONE_V);
      end
      @(negedge clk);
   endtask

   // Random operands and random back-pressure, summed by a serial adder model
   // and collected LSB first; the first frame is the 5A + 27 = 81 case.
   task automatic test_random_serial_add(input int frames);
      logic [W-1:0] a, b, col, exp_sum;
      logic         carry, cin, s, br;
      int           k, cyc;
      for (int f = 0; f < frames; f++) begin
         a = (f == 0) ? 8'h5A : W'($urandom);
         b = (f == 0) ? 8'h27 : W'($urandom);
         a_in = a; b_in = b; load_valid = 1'b1; bit_ready = 1'b1;
         @(negedge clk);
         load_valid = 1'b0;
         k = 0; cyc = 0; carry = 1'b0; col = '0;
         while (k < W && cyc < 200) begin
            checks++;
            if (obs_vec() !== beat_vec(a, b, k)) begin
               errors++; $display("FAIL rand_f%0d_beat%0d: got %b want %b", f, k, obs_vec(), beat_vec(a, b, k));
            end
            br = ($urandom_range(0, 3) != 0);
            bit_ready = br;
            if (br && bit_valid) begin
               cin   = first_bit ? 1'b0 : carry;
               s     = a_bit ^ b_bit ^ cin;
               carry = (a_bit & b_bit) | (a_bit & cin) | (b_bit & cin);
               col   = {s, col[W-1:1]};
               k++;
            end
            cyc++;
            @(negedge clk);
         end
         checks++;
         if (k < W) begin
            errors++; $display("FAIL rand_f%0d_timeout: got %0d beats want %0d", f, k, W);
         end
         checks++;
         if (obs_vec() !== DONE_V) begin
            errors++; $display("FAIL rand_f%0d_done: got %b want %b", f, obs_vec(), DONE_V);
         end
         exp_sum = a + b;
         checks++;
         if (col !== exp_sum) begin
            errors++; $display("FAIL rand_f%0d_sum: got %h want %h", f, col, exp_sum);
         end
         bit_ready = 1'(($urandom_range(0, 1)));
         @(negedge clk);
         checks++;
         if (obs_vec() !== IDLE_V) begin
            errors++; $display("FAIL rand_f%0d_idle: got %b want %b", f, obs_vec(), IDLE_V);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_mid_load();
      test_reset_mid();
      test_back_to_back();
      test_random_serial_add(20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/parallel_serial_shifter.md
Name: parallel_serial_shifter

Overview:
Parallel-to-serial front end of the serial adder datapath. It captures two WIDTH-bit operands in one handshake. It then streams them out one bit per accepted beat, LSB first, to the serial full adder. It drives the framing strobes (first_bit clears adder carry, last_bit ends the frame) that the downstream serial-to-parallel collector uses to assemble the sum.

Parameters:
WIDTH, 8, operand width in bits; legal range 1..64
CNT_W, $clog2(WIDTH) (min 1), localparam; bit-index counter width

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous reset, active-low
load_valid  input  1  operands on a_in/b_in are valid
load_ready  output  1  block can accept a new operand pair
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
bit_ready  input  1  downstream consumes the current bit this cycle
bit_valid  output  1  a_bit/b_bit valid (downstream shift enable)
a_bit  output  1  current bit of A
b_bit  output  1  current bit of B
first_bit  output  1  current beat is bit 0
last_bit  output  1  current beat is bit WIDTH-1
busy  output  1  frame in progress (SHIFT or DONE)
done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset: reset_n sampled low at a clk edge forces the following:
  - state=IDLE; a_sh=b_sh=0; cnt=0.
  - Outputs bit_valid/a_bit/b_bit/first_bit/last_bit/done/busy are 0.
  - load_ready=0 while reset_n is low.
- Reset mid-frame: the frame is abandoned and no done pulse is issued. The next frame starts cleanly.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid: capture a_sh<=a_in, b_sh<=b_in, cnt<=0, then go to SHIFT.
- SHIFT:
  - bit_valid=1; a_bit=a_sh[0]; b_bit=b_sh[0].
  - first_bit=(cnt==0); last_bit=(cnt==WIDTH-1).
  - Beat accepted when bit_valid && bit_ready. On acceptance: shift a_sh and b_sh right with zero fill, and cnt<=cnt+1.
  - Accepted beat with cnt==WIDTH-1: go to DONE.
  - bit_ready low: all state and outputs hold (stall, no bound on length).
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - load_ready=0 in DONE.
- Outputs outside SHIFT: a_bit, b_bit, first_bit and last_bit are 0 whenever bit_valid=0.
- busy=1 in SHIFT or DONE.
- Latency with no stalls:
  - load accepted at edge N; bit 0 presented in cycle N+1;
  - bit WIDTH-1 presented in cycle N+WIDTH;
  - done in cycle N+WIDTH+1;
  - next load accepted at the end of cycle N+WIDTH+2.
- WIDTH=1: first_bit and last_bit assert in the same beat.
- load_valid while load_ready=0: ignored; operand registers are not disturbed.
- load_valid and reset in the same cycle: reset wins.

Optional Feature:
P2S_PROTO_ERR_EN
- Defined:
  - Adds output proto_err (1 bit), reset to 0.
  - Set sticky on any cycle with load_valid=1 while state!=IDLE and reset_n=1.
  - Cleared only by reset.
- Not defined: the port is absent and no error logic is generated; behaviour is otherwise identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the WIDTH default constant (shared with the serial adder and serial-to-parallel collector);
  - typedef enum logic [1:0] p2s_state_t {IDLE, SHIFT, DONE}.
- Single module, no sub-module. The counter and both shift registers are inline because they share one advance condition.

Test Plan:
1. Reset, then load a_in=8'hA5, b_in=8'h3C, bit_ready=1 -> over 8 consecutive beats:
   - a_bit = 1,0,1,0,0,1,0,1 and b_bit = 0,0,1,1,1,1,0,0;
   - first_bit on beat 0 only, last_bit on beat 7 only;
   - done exactly 1 cycle later; load_ready returns the cycle after done.
2. Same load with bit_ready=0 during beats 2-4 -> a_bit holds 1 and cnt holds 2 through the stall. The sequence completes unchanged and done is delayed by 3 cycles.
3. load_valid pulsed with a_in=8'hFF mid-frame (beat 3) -> ignored and the remaining bits still come from 8'hA5. With P2S_PROTO_ERR_EN, proto_err=1 and stays 1 until reset.
4. reset_n=0 for one edge at beat 5 -> next cycle bit_valid=0, busy=0, and no done. A subsequent load of 8'h01/8'h01 streams correctly from bit 0.
5. Back-to-back loads 8'h0F/8'hF0 then 8'h81/8'h18 with load_valid held high -> the second load is accepted on the first IDLE cycle after done, and there is no bit loss or overlap.
6. Integration with the serial adder and the serial-to-parallel collector at WIDTH=8: A=8'h5A, B=8'h27 -> the collected sum equals 8'h81 after the frame completes.
